id_exe_pipe_reg: RTL

//  ID->EXE pipeline register with bubble insertion, flush and freeze. Captures decoded
//  ID fields each cycle and drives the EXE stage. Its exe_dest/exe_mem_r_en outputs

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/sat_counter.sv | 23 ++
 rtl/id_exe_pipe_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared ID->EXE pipeline definitions: branch encodings, the NOP command and the
// bundled field struct carried from decode into execute.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_REG_W  = 5;
    localparam int unsigned PIPE_CMD_W  = 4;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    localparam logic [PIPE_CMD_W-1:0] EXE_NOP = '0;

    typedef struct packed {
        logic [PIPE_DATA_W-1:0] pc;
        logic [PIPE_DATA_W-1:0] val1;
        logic [PIPE_DATA_W-1:0] val2;
        logic [PIPE_DATA_W-1:0] st_val;
        logic [PIPE_REG_W-1:0]  dest;
        logic [PIPE_REG_W-1:0]  src1;
        logic [PIPE_REG_W-1:0]  src2;
        logic [PIPE_CMD_W-1:0]  exe_cmd;
        logic                   mem_r_en;
        logic                   mem_w_en;
        logic                   wb_en;
        br_type_e               br_type;
    } id_exe_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with freeze, flush and hazard bubbles, plus saturating
// perf counters for bubbles caused by hazards and by flushes.
module id_exe_pipe_reg
    import pipe_pkg::*;
#(
    // Field widths must match the package struct widths.
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned REG_W  = PIPE_REG_W,
    parameter int unsigned CMD_W  = PIPE_CMD_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [CMD_W-1:0]  id_exe_cmd,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_wb_en,
    input  logic [1:0]        id_br_type,
    output logic              exe_valid,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_st_val,
    output logic [REG_W-1:0]  exe_dest,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [CMD_W-1:0]  exe_exe_cmd,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_wb_en,
    output logic [1:0]        exe_br_type,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    id_exe_t id_fields;
    id_exe_t fields_d, fields_q;
    logic    valid_d, valid_q;
    logic    flush_inc, bubble_inc;

    always_comb begin
        id_fields          = '0;
        id_fields.pc       = id_pc;
        id_fields.val1     = id_val1;
        id_fields.val2     = id_val2;
        id_fields.st_val   = id_st_val;
        id_fields.dest     = id_dest;
        id_fields.src1     = id_src1;
        id_fields.src2     = id_src2;
        id_fields.exe_cmd  = id_exe_cmd;
        id_fields.mem_r_en = id_mem_r_en;
        id_fields.mem_w_en = id_mem_w_en;
        id_fields.wb_en    = id_wb_en;
        id_fields.br_type  = br_type_e'(id_br_type);
    end

    always_comb begin
        fields_d = fields_q;
        valid_d  = valid_q;
        if (!freeze) begin
            if (flush || hazard) begin
                // Bubble: operand/PC fields are don't-care and simply held.
                valid_d           = 1'b0;
                fields_d.dest     = '0;
                fields_d.src1     = '0;
                fields_d.src2     = '0;
                fields_d.exe_cmd  = EXE_NOP;
                fields_d.mem_r_en = 1'b0;
                fields_d.mem_w_en = 1'b0;
                fields_d.wb_en    = 1'b0;
                fields_d.br_type  = BR_NONE;
            end else begin
                fields_d = id_fields;
                valid_d  = id_valid;
                // An invalid slot must be as side-effect free as a bubble.
                if (!id_valid) begin
                    fields_d.mem_r_en = 1'b0;
                    fields_d.mem_w_en = 1'b0;
                    fields_d.wb_en    = 1'b0;
                    fields_d.br_type  = BR_NONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fields_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            fields_q <= fields_d;
            valid_q  <= valid_d;
        end
    end

    // Simultaneous flush and hazard is accounted as a flush only.
    assign flush_inc  = !freeze && flush;
    assign bubble_inc = !freeze && !flush && hazard;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign exe_valid    = valid_q;
    assign exe_pc       = fields_q.pc;
    assign exe_val1     = fields_q.val1;
    assign exe_val2     = fields_q.val2;
    assign exe_st_val   = fields_q.st_val;
    assign exe_dest     = fields_q.dest;
    assign exe_src1     = fields_q.src1;
    assign exe_src2     = fields_q.src2;
    assign exe_exe_cmd  = fields_q.exe_cmd;
    assign exe_mem_r_en = fields_q.mem_r_en;
    assign exe_mem_w_en = fields_q.mem_w_en;
    assign exe_wb_en    = fields_q.wb_en;
    assign exe_br_type  = fields_q.br_type;

endmodule
